// File: rtl/div_issue_pkg.sv
// Shared definitions for the divide issue/writeback controller.
// Contents: datapath defaults, funct3 encodings, FSM state encoding,
//           special-case divide constants.
package div_issue_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  localparam logic [31:0] SIGNED_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES   = 32'hFFFF_FFFF;

  // funct3[2] marks a divide op, funct3[1] selects remainder, funct3[0] unsigned.
  typedef enum logic [2:0] {
    F3_DIV  = 3'b100,
    F3_DIVU = 3'b101,
    F3_REM  = 3'b110,
    F3_REMU = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_WB    = 3'd4
  } state_e;

endpackage

// File: rtl/div_fast_path.sv
// Combinational resolver for divides that never need the iterative divider.
// Ports: dividend_i/divisor_i/signed_i (operands being captured), cache_* (last
//        divider-computed op), hit_o (resolved here), quot_o/rem_o (results).
module div_fast_path
  import div_issue_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic          signed_i,
  input  logic          cache_vld_i,
  input  logic [DW-1:0] cache_dividend_i,
  input  logic [DW-1:0] cache_divisor_i,
  input  logic          cache_signed_i,
  input  logic [DW-1:0] cache_quot_i,
  input  logic [DW-1:0] cache_rem_i,
  output logic          hit_o,
  output logic [DW-1:0] quot_o,
  output logic [DW-1:0] rem_o
);

  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  logic div_zero;
  logic ovf;
  logic cache_hit;

  assign div_zero  = (divisor_i == '0);
  assign ovf       = signed_i && (dividend_i == MIN_NEG) && (divisor_i == '1);
  assign cache_hit = cache_vld_i && (cache_dividend_i == dividend_i) &&
                     (cache_divisor_i == divisor_i) && (cache_signed_i == signed_i);

  // Zero divisor and overflow take priority; the cache can never hold those
  // operand pairs anyway since they never reach the divider.
  always_comb begin
    hit_o  = div_zero || ovf || cache_hit;
    quot_o = cache_quot_i;
    rem_o  = cache_rem_i;
    if (div_zero) begin
      quot_o = '1;
      rem_o  = dividend_i;
    end else if (ovf) begin
      quot_o = MIN_NEG;
      rem_o  = '0;
    end
  end

endmodule

// File: rtl/div_issue.sv
// Issue/writeback controller between the execute stage and the iterative divider.
// Ports: req_valid_i/funct3_i/rs1_data_i/rs2_data_i/rd_addr_i/flush_i from the pipeline;
//        div_* to/from the divider; stall_o to the pipeline; wb_* to the register file.
module div_issue
  import div_issue_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  input  logic [2:0]    funct3_i,
  input  logic [DW-1:0] rs1_data_i,
  input  logic [DW-1:0] rs2_data_i,
  input  logic [RW-1:0] rd_addr_i,
  input  logic          flush_i,
  output logic          div_en_o,
  output logic          div_signed_o,
  output logic [DW-1:0] div_dividend_o,
  output logic [DW-1:0] div_divisor_o,
  input  logic [DW-1:0] div_quot_i,
  input  logic [DW-1:0] div_rem_i,
  input  logic          div_done_i,
  output logic          stall_o,
  output logic          wb_en_o,
  output logic [RW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_data_o
);

  state_e state_q, state_d;

  // Holding registers; they also drive the divider operands directly, so the
  // operands stay stable from ISSUE until the divider finishes.
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [2:0]    f3_q, f3_d;
  logic [DW-1:0] res_q;

  // Single-entry cache of the last divider-computed operation.
  logic          cv_q;
  logic [DW-1:0] ca_q, cb_q, cq_q, cr_q;
  logic          cs_q;

  logic          accept;
  logic          sgn_d;
  logic          fp_hit;
  logic [DW-1:0] fp_quot, fp_rem;

  assign accept = (state_q == S_IDLE) && req_valid_i && funct3_i[2] && !flush_i;

  assign a_d   = accept ? rs1_data_i : a_q;
  assign b_d   = accept ? rs2_data_i : b_q;
  assign rd_d  = accept ? rd_addr_i  : rd_q;
  assign f3_d  = accept ? funct3_i   : f3_q;
  // f3 resets to 0, so bit 2 keeps the signed flag low until a real capture.
  assign sgn_d = f3_d[2] && !f3_d[0];

  div_fast_path #(.DW(DW)) u_fast (
    .dividend_i       (a_d),
    .divisor_i        (b_d),
    .signed_i         (sgn_d),
    .cache_vld_i      (cv_q),
    .cache_dividend_i (ca_q),
    .cache_divisor_i  (cb_q),
    .cache_signed_i   (cs_q),
    .cache_quot_i     (cq_q),
    .cache_rem_i      (cr_q),
    .hit_o            (fp_hit),
    .quot_o           (fp_quot),
    .rem_o            (fp_rem)
  );

  assign div_dividend_o = a_q;
  assign div_divisor_o  = b_q;
  assign div_signed_o   = f3_q[2] && !f3_q[0];
  assign wb_addr_o      = rd_q;
  assign wb_data_o      = res_q;

  always_comb begin
    state_d  = state_q;
    div_en_o = 1'b0;
    stall_o  = 1'b0;
    wb_en_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall_o = accept;
        if (accept) state_d = fp_hit ? S_WB : S_ISSUE;
      end
      S_ISSUE: begin
        div_en_o = 1'b1;
        stall_o  = 1'b1;
        state_d  = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (div_done_i)   state_d = flush_i ? S_IDLE : S_WB;
        else if (flush_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Hold off a waiting request until the orphaned divide completes.
        stall_o = req_valid_i && funct3_i[2];
        if (div_done_i) state_d = S_IDLE;
      end
      S_WB: begin
        wb_en_o = !flush_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      res_q   <= '0;
      cv_q    <= 1'b0;
      ca_q    <= '0;
      cb_q    <= '0;
      cs_q    <= 1'b0;
      cq_q    <= '0;
      cr_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      if (accept && fp_hit)
        res_q <= funct3_i[1] ? fp_rem : fp_quot;
      else if ((state_q == S_WAIT) && div_done_i)
        res_q <= f3_q[1] ? div_rem_i : div_quot_i;
      // A flushed divide still refreshes the cache: its result is valid.
      if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && div_done_i) begin
        cv_q <= 1'b1;
        ca_q <= a_q;
        cb_q <= b_q;
        cs_q <= div_signed_o;
        cq_q <= div_quot_i;
        cr_q <= div_rem_i;
      end
    end
  end

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a fixed-latency behavioural divider.
// Ports: all DUT ports driven/observed; inputs change 1 time unit after posedge.
module tb_div_issue;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        div_en_o;
  logic        div_signed_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [31:0] div_quot_i;
  logic [31:0] div_rem_i;
  logic        div_done_i;
  logic        stall_o;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  int total = 0;
  int bad   = 0;
  int en_cnt  = 0;
  int ovl_cnt = 0;

  div_issue dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .funct3_i       (funct3_i),
    .rs1_data_i     (rs1_data_i),
    .rs2_data_i     (rs2_data_i),
    .rd_addr_i      (rd_addr_i),
    .flush_i        (flush_i),
    .div_en_o       (div_en_o),
    .div_signed_o   (div_signed_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_quot_i     (div_quot_i),
    .div_rem_i      (div_rem_i),
    .div_done_i     (div_done_i),
    .stall_o        (stall_o),
    .wb_en_o        (wb_en_o),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // Divider model: sampled on negedge, result 3 cycles after the enable cycle.
  initial begin
    bit          busy;
    int          cnt;
    logic [31:0] ma, mb;
    bit          msg;
    busy = 0; cnt = 0; ma = '0; mb = '0; msg = 0;
    div_done_i = 1'b0; div_quot_i = '0; div_rem_i = '0;
    forever begin
      @(negedge clk);
      div_done_i = 1'b0;
      if (rst) begin
        busy = 0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 0;
            div_done_i = 1'b1;
            if (msg) begin
              div_quot_i = $signed(ma) / $signed(mb);
              div_rem_i  = $signed(ma) % $signed(mb);
            end else begin
              div_quot_i = ma / mb;
              div_rem_i  = ma % mb;
            end
          end
        end
        if (div_en_o) begin
          en_cnt++;
          if (div_done_i) ovl_cnt++;
          busy = 1; cnt = 3;
          ma = div_dividend_o; mb = div_divisor_o; msg = div_signed_o;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then wait for its writeback and check latency, data, stall and enables.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    int en0;
    bit stall_ok;
    req_valid_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    #1;
    chk({tag, "_stall_acc"}, stall_o, 1);
    en0 = en_cnt;
    step();
    req_valid_i = 1'b0;
    lat = 1; stall_ok = 1;
    while (!wb_en_o && lat < 50) begin
      if (!stall_o) stall_ok = 0;
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_addr"}, wb_addr_o, rd);
    chk({tag, "_data"}, wb_data_o, exp);
    chk({tag, "_stall_busy"}, stall_ok, 1);
    chk({tag, "_stall_wb"}, stall_o, 0);
    chk({tag, "_en_pulses"}, en_cnt - en0, (exp_lat == 1) ? 0 : 1);
    step();
    chk({tag, "_wb_once"}, wb_en_o, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_div_en"}, div_en_o, 0);
    chk({tag, "_signed"}, div_signed_o, 0);
    chk({tag, "_dividend"}, div_dividend_o, 0);
    chk({tag, "_divisor"}, div_divisor_o, 0);
    chk({tag, "_wb_en"}, wb_en_o, 0);
    chk({tag, "_wb_addr"}, wb_addr_o, 0);
    chk({tag, "_wb_data"}, wb_data_o, 0);
    chk({tag, "_stall"}, stall_o, 0);
  endtask

  initial begin
    int lat;
    int en0;
    bit stall_ok;
    rst = 1'b1; req_valid_i = 1'b1; funct3_i = 3'b101; rs1_data_i = 32'd100;
    rs2_data_i = 32'd7; rd_addr_i = 5'd5; flush_i = 1'b0;
    step(); step();
    chk_zero("reset");
    req_valid_i = 1'b0;
    rst = 1'b0;
    step();

    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 5);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 5);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 1);
    run_op("divu_m7_2",  3'b101, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC, 5);
    run_op("div_5_0",    3'b100, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0",   3'b111, 32'd5, 32'd0, 5'd9, 32'd5, 1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);

    // Flush in the writeback cycle suppresses the write.
    req_valid_i = 1'b1; funct3_i = 3'b100; rs1_data_i = 32'd5; rs2_data_i = 32'd0; rd_addr_i = 5'd12;
    #1;
    chk("wbflush_acc", stall_o, 1);
    step();
    req_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("wbflush_wb_en", wb_en_o, 0);
    step();
    flush_i = 1'b0;
    #1;
    chk("wbflush_after", wb_en_o, 0);

    // Flush in WAIT with a new op held; it must wait out DRAIN.
    en0 = en_cnt;
    req_valid_i = 1'b1; funct3_i = 3'b101; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd9;
    step();
    req_valid_i = 1'b0;
    step();
    flush_i = 1'b1; req_valid_i = 1'b1; rs1_data_i = 32'd9; rs2_data_i = 32'd3; rd_addr_i = 5'd10;
    #1;
    chk("flush_stall_wait", stall_o, 1);
    step();
    flush_i = 1'b0;
    #1;
    chk("flush_stall_drain", stall_o, 1);
    lat = 3; stall_ok = 1;
    while (!wb_en_o && lat < 60) begin
      if (!stall_o) stall_ok = 0;
      step();
      lat++;
    end
    chk("flush_lat", lat, 10);
    chk("flush_addr", wb_addr_o, 10);
    chk("flush_data", wb_data_o, 3);
    chk("flush_stall_busy", stall_ok, 1);
    chk("flush_wb_no_accept", stall_o, 0);
    chk("flush_en_pulses", en_cnt - en0, 2);
    req_valid_i = 1'b0;
    step();

    run_op("divu_refill", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 5);

    // Reset in WAIT: everything cleared, cache forgotten.
    req_valid_i = 1'b1; funct3_i = 3'b101; rs1_data_i = 32'd50; rs2_data_i = 32'd7; rd_addr_i = 5'd11;
    step();
    req_valid_i = 1'b0;
    step();
    rst = 1'b1; req_valid_i = 1'b1;
    #1;
    chk_zero("midrst");
    step(); step();
    req_valid_i = 1'b0;
    rst = 1'b0;
    step();
    chk("midrst_no_wb", wb_en_o, 0);
    step();
    chk("midrst_no_wb2", wb_en_o, 0);
    run_op("divu_postrst", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 5);

    chk("en_done_overlap", ovl_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_issue.md
# div_issue

Issue/writeback controller for the M-extension divide unit, sitting in the execute stage between the pipeline and the iterative divider. Accepts DIV/DIVU/REM/REMU requests, resolves divide-by-zero, signed overflow and repeated-operand cases itself in one cycle, and otherwise launches the divider and waits for its result. Drives the pipeline stall and the register-file write port for divide results.

## Interface
- DW, 32, datapath width
- RW, 5, register address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  divide op present in execute stage
- funct3_i  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3_i[2]=0 means not a divide op
- rs1_data_i  in  DW  dividend
- rs2_data_i  in  DW  divisor
- rd_addr_i  in  RW  destination register
- flush_i  in  1  kill in-flight instruction
- div_en_o  out  1  divider start pulse
- div_signed_o  out  1  signed operation (= ~funct3[0])
- div_dividend_o, div_divisor_o  out  DW  divider operands
- div_quot_i, div_rem_i  in  DW  divider results
- div_done_i  in  1  divider result valid (its write-enable)
- stall_o  out  1  hold pipeline
- wb_en_o  out  1  register write enable
- wb_addr_o  out  RW  register write address
- wb_data_o  out  DW  register write data

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, WB.
- IDLE: request accepted when req_valid_i & funct3_i[2] & ~flush_i; capture rs1, rs2, rd, funct3 into holding registers.
- Fast path, decided from captured values, next state WB, divider untouched:
  - divisor 0: quotient all-ones, remainder = dividend (signed and unsigned).
  - signed, dividend 0x8000_0000, divisor all-ones: quotient 0x8000_0000, remainder 0.
  - cache hit: valid & dividend, divisor, signedness match last divider-computed operation; cached quotient and remainder reused.
- Slow path: IDLE -> ISSUE (div_en_o=1 exactly one cycle) -> WAIT until div_done_i=1 -> WB. On the done edge, capture quotient/remainder into result registers and cache (key + both results, valid=1).
- Special-case results are not written into the cache.
- Result selected by funct3[1]: 0 quotient, 1 remainder.
- div_dividend_o/div_divisor_o/div_signed_o are registered from the holding registers and stay stable from ISSUE until done.
- WB: wb_en_o=1 for one cycle with wb_addr_o=rd, wb_data_o=result; then IDLE.
- flush_i in ISSUE or WAIT: go to DRAIN (div_en_o still pulses if in ISSUE); on div_done_i, update cache, no writeback, go to IDLE.
- flush_i in WB: wb_en_o forced 0 that cycle.
- stall_o (combinational): 1 in ISSUE/WAIT; in IDLE equals acceptance condition; in DRAIN equals req_valid_i & funct3_i[2]; 0 in WB and during rst.
- Reset mid-operation: all state cleared, cache invalidated, no writeback; divider shares rst.

## Timing
- Reset values: div_en_o 0, div_signed_o 0, div_dividend_o 0, div_divisor_o 0, wb_en_o 0, wb_addr_o 0, wb_data_o 0, stall_o 0; state IDLE; cache invalid.
- Cycle 0 = acceptance edge. Fast path: wb_en_o high in cycle 1; stall_o high in cycle 0 only.
- Slow path: div_en_o high in cycle 1; WB is the cycle after div_done_i is first seen high; stall_o high from cycle 0 through the done cycle.
- div_en_o never high while div_done_i is high (divider restarts if enable is seen in its done cycle).
- New request seen in WB cycle is not accepted; it is accepted in the following IDLE cycle.

## Structure
- Shared package: funct3 encodings, state encoding, DW/RW defaults, constants SIGNED_MIN (0x8000_0000) and ALL_ONES.
- One sub-module: div_fast_path, combinational; inputs captured operands, signedness and cache contents; outputs hit flag plus quotient/remainder for zero-divisor, overflow and cache-hit cases.
- FSM, holding registers, cache registers and writeback registers live in div_issue.

## Test plan
- DIVU 100/7, rd=5 -> one-cycle div_en_o, stall until done, wb_en_o with wb_addr_o=5, wb_data_o=14.
- DIV -7/2 then REM -7/2 -> first wb 0xFFFF_FFFD after divider; second wb 0xFFFF_FFFF one cycle after acceptance, div_en_o never asserted.
- DIV 5/0 and REMU 5/0 -> wb 0xFFFF_FFFF and 5, each one cycle after acceptance, no div_en_o.
- DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM same -> 0; no div_en_o.
- flush_i in WAIT, new DIVU 9/3 held on req_valid_i -> no wb_en_o for flushed op, stall_o high during DRAIN, new op accepted after div_done_i, wb 3.
- rst asserted during WAIT, then DIVU 100/7 repeated -> all outputs 0 during reset, cache miss, full slow path, wb 14.
